my_spi: RTL and testbench
=========================

MY_SPI -- requirements
Module: my_spi

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for SPI inputs; legal range 2..4.
REQ-002 Parameter CPOL, default 0: idle level of iSPIClk.
REQ-003 Parameter CPHA, default 0: 0 samples on leading edge, 1 on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1: 1 shifts MSB first, 0 shifts LSB first.
REQ-005 sysclk  input  1  system clock, the only clock; all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 iSPIClk  input  1  SPI serial clock, asynchronous to sysclk.
REQ-008 iSPIMOSI  input  1  SPI data in, asynchronous.
REQ-009 iSPICS  input  1  SPI chip select, active-low, asynchronous.
REQ-010 oRx  output  8  last completely received byte.
REQ-011 oRxReady  output  1  one-sysclk pulse per completed byte.
REQ-012 probe  output  8  debug status bus (see Configuration).

Function
REQ-013 iSPIClk, iSPIMOSI and iSPICS SHALL each pass through SYNC_STAGES flops; all later logic uses only the synchronized copies.
REQ-014 Sample edge SHALL be the synchronized iSPIClk rising edge when CPOL==CPHA, and the falling edge otherwise; detect it by comparing the last two synchronized SCK samples.
REQ-015 A sample edge SHALL be honored only while synchronized CS is low; SCK edges while CS is high are ignored.
REQ-016 On each honored edge, the synchronized MOSI bit SHALL shift into an 8-bit shift register: toward the MSB when MSB_FIRST=1, toward the LSB otherwise. The 3-bit bit counter SHALL increment.
REQ-017 On the 8th honored edge (counter 7 -> 0 wrap), oRx SHALL load the assembled byte and oRxReady SHALL be 1 for exactly the next sysclk cycle.
REQ-018 oRx SHALL hold its value until the next completed byte; oRxReady SHALL be 0 at all other times.
REQ-019 Latency from the physical 8th sample edge to oRxReady high SHALL be SYNC_STAGES+2 sysclk cycles, or fewer.
REQ-020 Back-to-back bytes within one CS-low frame SHALL be supported without gaps; the counter wraps and continues.
REQ-021 Synchronized CS high SHALL clear the bit counter and shift register within one cycle. A partial byte is discarded, produces no pulse, and leaves oRx unchanged.
REQ-022 If CS deassertion and a sample edge are seen in the same cycle, the CS deassertion wins and the edge is ignored.
REQ-023 Supported iSPIClk frequency SHALL be at most sysclk/4, with each SCK phase at least 2 sysclk periods.

Reset
REQ-024 Reset SHALL have priority over all other events.
REQ-025 Values while reset is asserted: oRx=8'h00, oRxReady=0, counter=0, shift register=0.
REQ-026 Synchronizer flops SHALL reset to idle: CS=1, SCK=CPOL, MOSI=0.
REQ-027 Reset mid-byte SHALL discard the partial byte with no pulse; reception resumes at the next CS-low frame.

Configuration
REQ-028 Macro MY_SPI_PROBE_EN defined SHALL drive probe as: [7]=synced CS, [6]=synced SCK, [5]=synced MOSI, [4]=in-frame (synced CS low), [3]=0, [2:0]=bit counter.
REQ-029 Without MY_SPI_PROBE_EN, probe SHALL be constant 8'h00 and no probe logic is generated.

Structure
REQ-030 Package my_spi_pkg SHALL hold BYTE_W=8, BITCNT_W=3 and the probe bit-index constants.
REQ-031 One sub-module, my_spi_sync (parameterized N-stage single-bit synchronizer with reset value), SHALL be instantiated three times.

Verification
REQ-032 Mode 0, CS low, send 0xA5 MSB-first at sysclk/8 -> exactly one oRxReady pulse; oRx=0xA5.
REQ-033 0x3C then 0xC3 in one CS frame -> two pulses; oRx=0x3C after the first, 0xC3 after the second.
REQ-034 CS raised after 5 bits of 0xFF, then a new frame with 0x12 -> no pulse for the partial byte; single pulse after the new frame; oRx=0x12.
REQ-035 Reset asserted after 4 bits, then a full frame with 0x81 -> oRx=0x00 and no pulse during reset; after the frame, one pulse and oRx=0x81.
REQ-036 SCK toggled 16 times with CS high -> no pulse; oRx unchanged.
REQ-037 Probe: with MY_SPI_PROBE_EN, after 3 bits in a frame -> probe[2:0]=3 and probe[4]=1; without the macro -> probe=8'h00 throughout.

Source files
------------

// File: rtl/my_spi_pkg.sv
// Shared widths and debug-probe bit positions for the my_spi SPI receiver.
package my_spi_pkg;

    localparam int BYTE_W   = 8;
    localparam int BITCNT_W = 3;

    // Bit positions inside the probe bus
    localparam int PRB_CS      = 7;
    localparam int PRB_SCK     = 6;
    localparam int PRB_MOSI    = 5;
    localparam int PRB_INFRAME = 4;
    localparam int PRB_RSVD    = 3;
    localparam int PRB_CNT_HI  = 2;
    localparam int PRB_CNT_LO  = 0;

endpackage

// File: rtl/my_spi_sync.sv
// N-stage single-bit synchronizer with a configurable reset (idle) value.
module my_spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sysclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge sysclk) begin
        if (reset) ff <= {N{RST_VAL}};
        else       ff <= {ff[N-2:0], d};
    end

    assign q = ff[N-1];

endmodule

// File: rtl/my_spi.sv
// SPI slave receiver: oversampled by sysclk, one oRxReady pulse per byte.
// Optional debug bus enabled with macro MY_SPI_PROBE_EN.
module my_spi
    import my_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              iSPIClk,
    input  logic              iSPIMOSI,
    input  logic              iSPICS,
    output logic [BYTE_W-1:0] oRx,
    output logic              oRxReady,
    output logic [7:0]        probe
);

    localparam logic SCK_IDLE = (CPOL != 0);

    logic sck_s, mosi_s, cs_s;
    logic sck_q;
    logic sample_edge;
    logic [BYTE_W-1:0]   shreg;
    logic [BYTE_W-1:0]   next_byte;
    logic [BITCNT_W-1:0] bit_cnt;

    my_spi_sync #(.N(SYNC_STAGES), .RST_VAL(SCK_IDLE)) u_sync_sck (
        .sysclk(sysclk), .reset(reset), .d(iSPIClk),  .q(sck_s)
    );
    my_spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .sysclk(sysclk), .reset(reset), .d(iSPIMOSI), .q(mosi_s)
    );
    my_spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .sysclk(sysclk), .reset(reset), .d(iSPICS),   .q(cs_s)
    );

    // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling
    always_comb begin
        if (CPOL == CPHA) sample_edge = sck_s & ~sck_q;
        else              sample_edge = ~sck_s & sck_q;
    end

    always_comb begin
        if (MSB_FIRST != 0) next_byte = {shreg[BYTE_W-2:0], mosi_s};
        else                next_byte = {mosi_s, shreg[BYTE_W-1:1]};
    end

    // CS high takes precedence over a coincident sample edge
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sck_q    <= SCK_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            oRx      <= '0;
            oRxReady <= 1'b0;
        end else begin
            sck_q    <= sck_s;
            oRxReady <= 1'b0;
            if (cs_s) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (sample_edge) begin
                shreg   <= next_byte;
                bit_cnt <= bit_cnt + BITCNT_W'(1);
                if (bit_cnt == BITCNT_W'(BYTE_W - 1)) begin
                    oRx      <= next_byte;
                    oRxReady <= 1'b1;
                end
            end
        end
    end

`ifdef MY_SPI_PROBE_EN
    always_comb begin
        probe                        = '0;
        probe[PRB_CS]                = cs_s;
        probe[PRB_SCK]               = sck_s;
        probe[PRB_MOSI]              = mosi_s;
        probe[PRB_INFRAME]           = ~cs_s;
        probe[PRB_RSVD]              = 1'b0;
        probe[PRB_CNT_HI:PRB_CNT_LO] = bit_cnt;
    end
`else
    assign probe = '0;
`endif

endmodule

// File: tb/tb_my_spi.sv
// Directed bench for my_spi in mode 0, MSB first, SCK at sysclk/8.
module tb_my_spi;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       iSPIClk;
    logic       iSPIMOSI;
    logic       iSPICS;
    logic [7:0] oRx;
    logic       oRxReady;
    logic [7:0] probe;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int wide_cnt = 0;
    int probe_nz = 0;
    logic prev_ready = 1'b0;
    logic [7:0] cap [0:63];

    my_spi dut (
        .sysclk(sysclk), .reset(reset), .iSPIClk(iSPIClk), .iSPIMOSI(iSPIMOSI),
        .iSPICS(iSPICS), .oRx(oRx), .oRxReady(oRxReady), .probe(probe)
    );

    always #5 sysclk = ~sysclk;

    // Pulse bookkeeping sampled mid-cycle
    always @(negedge sysclk) begin
        prev_ready <= oRxReady;
        if (oRxReady === 1'b1) begin
            cap[pulse_cnt[5:0]] <= oRx;
            pulse_cnt <= pulse_cnt + 1;
            if (prev_ready === 1'b1) wide_cnt <= wide_cnt + 1;
        end
        if (probe !== 8'h00) probe_nz <= probe_nz + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sysclk);
    endtask

    // Sends the top n bits of b, MSB first; SCK half period = 4 sysclk
    task automatic send_bits(input logic [7:0] b, input int n);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < n; i++) begin
            iSPIMOSI = v[7];
            v = {v[6:0], 1'b0};
            cyc(4);
            iSPIClk = 1'b1;
            cyc(4);
            iSPIClk = 1'b0;
        end
    endtask

    initial begin
        int base;
        logic [7:0] tail;

        iSPICS = 1'b1; iSPIClk = 1'b0; iSPIMOSI = 1'b0; reset = 1'b1;
        cyc(5);
        @(negedge sysclk);
        check("reset_rx", oRx, 8'h00);
        check("reset_ready", oRxReady, 1'b0);
        reset = 1'b0;
        cyc(5);

        // Single byte 0xA5, with a probe snapshot after 3 bits
        base = pulse_cnt;
        iSPICS = 1'b0;
        cyc(4);
        send_bits(8'hA5, 3);
        cyc(8);
        @(negedge sysclk);
`ifdef MY_SPI_PROBE_EN
        check("probe_cnt3", probe[2:0], 3'd3);
        check("probe_inframe", probe[4], 1'b1);
`else
        check("probe_zero_mid", probe, 8'h00);
`endif
        check("a5_no_early_pulse", pulse_cnt - base, 0);
        tail = 8'hA5 << 3;
        send_bits(tail, 5);
        cyc(10);
        check("a5_pulses", pulse_cnt - base, 1);
        check("a5_rx", oRx, 8'hA5);
        iSPICS = 1'b1;
        cyc(8);

        // Two bytes back to back in one frame
        base = pulse_cnt;
        iSPICS = 1'b0;
        cyc(4);
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 8);
        cyc(10);
        check("b2b_pulses", pulse_cnt - base, 2);
        check("b2b_first", cap[base[5:0]], 8'h3C);
        check("b2b_second", cap[6'(base + 1)], 8'hC3);
        check("b2b_rx", oRx, 8'hC3);
        iSPICS = 1'b1;
        cyc(8);

        // Partial byte aborted by CS, then a fresh frame
        base = pulse_cnt;
        iSPICS = 1'b0;
        cyc(4);
        send_bits(8'hFF, 5);
        iSPICS = 1'b1;
        cyc(8);
        @(negedge sysclk);
        check("partial_no_pulse", pulse_cnt - base, 0);
        check("partial_rx_hold", oRx, 8'hC3);
`ifdef MY_SPI_PROBE_EN
        check("partial_cnt_clr", probe[2:0], 3'd0);
`endif
        iSPICS = 1'b0;
        cyc(4);
        send_bits(8'h12, 8);
        cyc(10);
        check("new_frame_pulses", pulse_cnt - base, 1);
        check("new_frame_rx", oRx, 8'h12);
        iSPICS = 1'b1;
        cyc(8);

        // Reset in the middle of a byte
        base = pulse_cnt;
        iSPICS = 1'b0;
        cyc(4);
        send_bits(8'h81, 4);
        reset = 1'b1;
        cyc(3);
        @(negedge sysclk);
        check("midrst_rx", oRx, 8'h00);
        check("midrst_ready", oRxReady, 1'b0);
        iSPICS = 1'b1;
        cyc(4);
        reset = 1'b0;
        cyc(6);
        check("midrst_no_pulse", pulse_cnt - base, 0);
        iSPICS = 1'b0;
        cyc(4);
        send_bits(8'h81, 8);
        cyc(10);
        check("after_rst_pulses", pulse_cnt - base, 1);
        check("after_rst_rx", oRx, 8'h81);
        iSPICS = 1'b1;
        cyc(8);

        // SCK activity with CS high is ignored
        base = pulse_cnt;
        for (int i = 0; i < 16; i++) begin
            iSPIMOSI = i[0];
            iSPIClk = ~iSPIClk;
            cyc(4);
        end
        cyc(10);
        check("cs_high_no_pulse", pulse_cnt - base, 0);
        check("cs_high_rx_hold", oRx, 8'h81);

        check("pulse_width", wide_cnt, 0);
`ifndef MY_SPI_PROBE_EN
        check("probe_always_zero", probe_nz, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
